// File: rtl/data_mem_ctrl.sv
// Byte-addressed big-endian data memory with a req/ready handshake, programmable wait states
// and byte/halfword/word/doubleword transfers. Mem is left unreset so it can be preloaded.
module data_mem_ctrl #(
    parameter int unsigned ADDR_WIDTH  = 9,
    parameter int unsigned WAIT_CYCLES = 0
) (
    input  logic                  clk,
    input  logic                  clr,
    input  logic                  req,
    input  logic                  rw,
    input  logic [1:0]            size,
    input  logic                  signed_ld,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [31:0]           data_in,
    output logic [31:0]           data_out,
    output logic                  busy,
    output logic                  ready,
    output logic                  dw_second,
    output logic                  misaligned
);

    localparam int unsigned Depth = 2 ** ADDR_WIDTH;

    localparam logic [1:0] SzByte = 2'b00;
    localparam logic [1:0] SzHalf = 2'b01;
    localparam logic [1:0] SzWord = 2'b10;
    localparam logic [1:0] SzDbl  = 2'b11;

    typedef enum logic [1:0] {StIdle, StWait, StXfer2, StDone} state_e;

    logic [7:0] Mem [Depth];

    state_e                state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [1:0]            size_q, size_d;
    logic                  rw_q, rw_d;
    logic                  sext_q, sext_d;
    logic [31:0]           data_out_q, data_out_d;
    logic                  ready_q, ready_d;
    logic                  dw_second_q, dw_second_d;
    logic                  misaligned_q, misaligned_d;

    logic                  req_misaligned;
    logic                  do_access;
    logic                  do_store;
    logic [ADDR_WIDTH-1:0] acc_a0, acc_a1, acc_a2, acc_a3;
    logic [7:0]            rd_b0, rd_b1, rd_b2, rd_b3;
    logic [31:0]           load_data;

    always_comb begin
        req_misaligned = 1'b0;
        case (size)
            SzHalf:  req_misaligned = addr[0];
            SzWord:  req_misaligned = (addr[1:0] != 2'b00);
            SzDbl:   req_misaligned = (addr[2:0] != 3'b000);
            default: req_misaligned = 1'b0;
        endcase
    end

    // The second doubleword beat targets the word following the latched address.
    assign acc_a0 = (state_q == StXfer2) ? addr_q + ADDR_WIDTH'(4) : addr_q;
    assign acc_a1 = acc_a0 + ADDR_WIDTH'(1);
    assign acc_a2 = acc_a0 + ADDR_WIDTH'(2);
    assign acc_a3 = acc_a0 + ADDR_WIDTH'(3);

    assign rd_b0 = Mem[acc_a0];
    assign rd_b1 = Mem[acc_a1];
    assign rd_b2 = Mem[acc_a2];
    assign rd_b3 = Mem[acc_a3];

    always_comb begin
        load_data = {rd_b0, rd_b1, rd_b2, rd_b3};
        case (size_q)
            SzByte:  load_data = {{24{sext_q & rd_b0[7]}}, rd_b0};
            SzHalf:  load_data = {{16{sext_q & rd_b0[7]}}, rd_b0, rd_b1};
            default: load_data = {rd_b0, rd_b1, rd_b2, rd_b3};
        endcase
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        addr_d       = addr_q;
        size_d       = size_q;
        rw_d         = rw_q;
        sext_d       = sext_q;
        ready_d      = 1'b0;
        dw_second_d  = 1'b0;
        misaligned_d = 1'b0;
        do_access    = 1'b0;
        case (state_q)
            StIdle: begin
                if (req) begin
                    if (req_misaligned) begin
                        misaligned_d = 1'b1;
                    end else begin
                        addr_d  = addr;
                        size_d  = size;
                        rw_d    = rw;
                        sext_d  = signed_ld;
                        cnt_d   = 4'(WAIT_CYCLES);
                        state_d = StWait;
                    end
                end
            end
            StWait: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    do_access = 1'b1;
                    ready_d   = 1'b1;
                    state_d   = (size_q == SzDbl) ? StXfer2 : StDone;
                end
            end
            StXfer2: begin
                do_access   = 1'b1;
                ready_d     = 1'b1;
                dw_second_d = 1'b1;
                state_d     = StDone;
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign do_store   = do_access & rw_q;
    assign data_out_d = (do_access && !rw_q) ? load_data : data_out_q;

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q      <= StIdle;
            cnt_q        <= 4'd0;
            addr_q       <= '0;
            size_q       <= SzByte;
            rw_q         <= 1'b0;
            sext_q       <= 1'b0;
            data_out_q   <= 32'd0;
            ready_q      <= 1'b0;
            dw_second_q  <= 1'b0;
            misaligned_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            addr_q       <= addr_d;
            size_q       <= size_d;
            rw_q         <= rw_d;
            sext_q       <= sext_d;
            data_out_q   <= data_out_d;
            ready_q      <= ready_d;
            dw_second_q  <= dw_second_d;
            misaligned_q <= misaligned_d;
        end
    end

    // Store lanes mirror the load byte ordering: data_in[7:0] lands at the highest address.
    always_ff @(posedge clk) begin
        if (do_store) begin
            case (size_q)
                SzByte: begin
                    Mem[acc_a0] <= data_in[7:0];
                end
                SzHalf: begin
                    Mem[acc_a0] <= data_in[15:8];
                    Mem[acc_a1] <= data_in[7:0];
                end
                default: begin
                    Mem[acc_a0] <= data_in[31:24];
                    Mem[acc_a1] <= data_in[23:16];
                    Mem[acc_a2] <= data_in[15:8];
                    Mem[acc_a3] <= data_in[7:0];
                end
            endcase
        end
    end

    assign data_out   = data_out_q;
    assign busy       = (state_q != StIdle);
    assign ready      = ready_q;
    assign dw_second  = dw_second_q;
    assign misaligned = misaligned_q;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Directed bench for data_mem_ctrl: one instance with two wait states, a second with three
// for the abort-on-reset case.
module tb_data_mem_ctrl;

    logic        clk = 1'b0;
    logic        clr = 1'b1;
    logic        clr3 = 1'b0;
    logic        sel3 = 1'b0;
    logic        req = 1'b0;
    logic        rw = 1'b0;
    logic [1:0]  size = 2'b00;
    logic        signed_ld = 1'b0;
    logic [8:0]  addr = '0;
    logic [31:0] data_in = '0;

    logic        req_a, req_b, clr_b;
    logic [31:0] data_out_a, data_out_b;
    logic        busy_a, busy_b, ready_a, ready_b, dws_a, dws_b, mis_a, mis_b;

    logic [31:0] obs_data;
    logic        obs_busy, obs_ready, obs_dws, obs_mis;

    int vectors = 0;
    int miscompares = 0;
    int both_cnt = 0;

    int          o_busy, o_first, o_rcnt, o_mis;
    logic [31:0] o_d0, o_d1;
    logic        o_s0, o_s1;

    always #5 clk = ~clk;

    assign req_a = req & ~sel3;
    assign req_b = req & sel3;
    assign clr_b = clr | clr3;

    assign obs_data  = sel3 ? data_out_b : data_out_a;
    assign obs_busy  = sel3 ? busy_b : busy_a;
    assign obs_ready = sel3 ? ready_b : ready_a;
    assign obs_dws   = sel3 ? dws_b : dws_a;
    assign obs_mis   = sel3 ? mis_b : mis_a;

    data_mem_ctrl #(.ADDR_WIDTH(9), .WAIT_CYCLES(2)) u_dut (
        .clk        (clk),
        .clr        (clr),
        .req        (req_a),
        .rw         (rw),
        .size       (size),
        .signed_ld  (signed_ld),
        .addr       (addr),
        .data_in    (data_in),
        .data_out   (data_out_a),
        .busy       (busy_a),
        .ready      (ready_a),
        .dw_second  (dws_a),
        .misaligned (mis_a)
    );

    data_mem_ctrl #(.ADDR_WIDTH(9), .WAIT_CYCLES(3)) u_dut3 (
        .clk        (clk),
        .clr        (clr_b),
        .req        (req_b),
        .rw         (rw),
        .size       (size),
        .signed_ld  (signed_ld),
        .addr       (addr),
        .data_in    (data_in),
        .data_out   (data_out_b),
        .busy       (busy_b),
        .ready      (ready_b),
        .dw_second  (dws_b),
        .misaligned (mis_b)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Presents a request for one clock; returns at the falling edge after the accepting edge.
    task automatic do_req(input logic w, input logic [1:0] sz, input logic sx,
                          input logic [8:0] a, input logic [31:0] d);
        @(negedge clk);
        req = 1'b1; rw = w; size = sz; signed_ld = sx; addr = a; data_in = d;
        @(negedge clk);
        req = 1'b0;
    endtask

    // Samples 20 cycles; index 0 is the cycle right after the accepting edge.
    task automatic observe(input bit pulse);
        o_busy = 0; o_first = -1; o_rcnt = 0; o_mis = 0;
        o_d0 = '0; o_d1 = '0; o_s0 = 1'b0; o_s1 = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (obs_busy) o_busy++;
            if (obs_mis) o_mis++;
            if (obs_ready && obs_mis) both_cnt++;
            if (obs_ready) begin
                if (o_rcnt == 0) begin
                    o_first = i; o_d0 = obs_data; o_s0 = obs_dws;
                end else begin
                    o_d1 = obs_data; o_s1 = obs_dws;
                end
                o_rcnt++;
            end
            // A stray byte store of FF to address 0 while the controller is busy.
            if (pulse && i == 1) begin
                req = 1'b1; rw = 1'b1; size = 2'b00; addr = 9'd0; data_in = 32'hFF;
            end
            if (pulse && i == 2) req = 1'b0;
            @(negedge clk);
        end
    endtask

    initial begin
        for (int i = 0; i < 512; i++) begin
            u_dut.Mem[i]  = 8'h00;
            u_dut3.Mem[i] = 8'h00;
        end
        u_dut.Mem[0] = 8'h81; u_dut.Mem[1] = 8'h02; u_dut.Mem[2] = 8'h03; u_dut.Mem[3] = 8'h04;
        u_dut.Mem[4] = 8'h05; u_dut.Mem[5] = 8'h06; u_dut.Mem[6] = 8'h07; u_dut.Mem[7] = 8'h08;
        u_dut.Mem[504] = 8'hA0; u_dut.Mem[505] = 8'hA1;
        u_dut.Mem[506] = 8'hA2; u_dut.Mem[507] = 8'hA3;
        u_dut.Mem[508] = 8'hB0; u_dut.Mem[509] = 8'hB1;
        u_dut.Mem[510] = 8'hB2; u_dut.Mem[511] = 8'hB3;
        u_dut3.Mem[8]  = 8'hC0; u_dut3.Mem[9]  = 8'hC1;
        u_dut3.Mem[10] = 8'hC2; u_dut3.Mem[11] = 8'hC3;

        repeat (2) @(negedge clk);
        check("rst_data_out", data_out_a, 32'h0);
        check("rst_busy", 32'(busy_a), 32'd0);
        check("rst_ready", 32'(ready_a), 32'd0);
        check("rst_dw_second", 32'(dws_a), 32'd0);
        check("rst_misaligned", 32'(mis_a), 32'd0);
        clr = 1'b0;
        @(negedge clk);

        // Word load, two wait states.
        do_req(1'b0, 2'b10, 1'b0, 9'd0, 32'h0);
        observe(1'b0);
        check("ldw0_ready_idx", 32'(o_first), 32'd3);
        check("ldw0_ready_cnt", 32'(o_rcnt), 32'd1);
        check("ldw0_busy_cycles", 32'(o_busy), 32'd4);
        check("ldw0_data", o_d0, 32'h81020304);
        check("ldw0_dws", 32'(o_s0), 32'd0);

        // Sign/zero extension.
        do_req(1'b0, 2'b00, 1'b1, 9'd0, 32'h0);
        observe(1'b0);
        check("ldb_signed", o_d0, 32'hFFFFFF81);
        do_req(1'b0, 2'b00, 1'b0, 9'd0, 32'h0);
        observe(1'b0);
        check("ldb_unsigned", o_d0, 32'h00000081);
        do_req(1'b0, 2'b01, 1'b1, 9'd0, 32'h0);
        observe(1'b0);
        check("ldh_signed", o_d0, 32'hFFFF8102);
        do_req(1'b0, 2'b01, 1'b0, 9'd0, 32'h0);
        observe(1'b0);
        check("ldh_unsigned", o_d0, 32'h00008102);

        // Doubleword with a stray request mid-transfer.
        do_req(1'b0, 2'b11, 1'b0, 9'd0, 32'h0);
        observe(1'b1);
        check("ldd_ready_cnt", 32'(o_rcnt), 32'd2);
        check("ldd_ready_idx", 32'(o_first), 32'd3);
        check("ldd_busy_cycles", 32'(o_busy), 32'd5);
        check("ldd_word0", o_d0, 32'h81020304);
        check("ldd_dws0", 32'(o_s0), 32'd0);
        check("ldd_word1", o_d1, 32'h05060708);
        check("ldd_dws1", 32'(o_s1), 32'd1);

        // Stores and read-back.
        do_req(1'b1, 2'b00, 1'b0, 9'd5, 32'h000000AA);
        observe(1'b0);
        check("stb_ready_cnt", 32'(o_rcnt), 32'd1);
        check("stb_data_out_held", data_out_a, 32'h05060708);
        do_req(1'b0, 2'b10, 1'b0, 9'd4, 32'h0);
        observe(1'b0);
        check("ldw4_after_stb", o_d0, 32'h05AA0708);
        do_req(1'b1, 2'b01, 1'b0, 9'd2, 32'h0000BEEF);
        observe(1'b0);
        do_req(1'b0, 2'b10, 1'b0, 9'd0, 32'h0);
        observe(1'b0);
        check("ldw0_after_sth", o_d0, 32'h8102BEEF);

        // Misaligned requests.
        do_req(1'b0, 2'b10, 1'b0, 9'd2, 32'h0);
        observe(1'b0);
        check("misw_pulses", 32'(o_mis), 32'd1);
        check("misw_busy", 32'(o_busy), 32'd0);
        check("misw_ready", 32'(o_rcnt), 32'd0);
        check("misw_data_held", data_out_a, 32'h8102BEEF);
        do_req(1'b1, 2'b10, 1'b0, 9'd1, 32'hFFFFFFFF);
        observe(1'b0);
        check("missw_pulses", 32'(o_mis), 32'd1);
        do_req(1'b0, 2'b01, 1'b0, 9'd3, 32'h0);
        observe(1'b0);
        check("mish_pulses", 32'(o_mis), 32'd1);
        do_req(1'b0, 2'b10, 1'b0, 9'd0, 32'h0);
        observe(1'b0);
        check("ldw0_after_mis", o_d0, 32'h8102BEEF);
        do_req(1'b0, 2'b11, 1'b0, 9'd4, 32'h0);
        observe(1'b0);
        check("misd_pulses", 32'(o_mis), 32'd1);
        check("misd_ready", 32'(o_rcnt), 32'd0);

        // Doubleword at the top of the array.
        do_req(1'b0, 2'b11, 1'b0, 9'd504, 32'h0);
        observe(1'b0);
        check("ldd504_word0", o_d0, 32'hA0A1A2A3);
        check("ldd504_word1", o_d1, 32'hB0B1B2B3);
        check("ldd504_misaligned", 32'(o_mis), 32'd0);

        // Reset mid-WAIT on the three-wait-state instance.
        sel3 = 1'b1;
        do_req(1'b1, 2'b10, 1'b0, 9'd8, 32'h12345678);
        check("abort_busy_before", 32'(busy_b), 32'd1);
        @(negedge clk);
        clr3 = 1'b1;
        #1;
        check("abort_busy", 32'(busy_b), 32'd0);
        check("abort_ready", 32'(ready_b), 32'd0);
        @(negedge clk);
        clr3 = 1'b0;
        repeat (3) @(negedge clk);
        do_req(1'b0, 2'b10, 1'b0, 9'd8, 32'h0);
        observe(1'b0);
        check("abort_bytes_kept", o_d0, 32'hC0C1C2C3);
        check("w3_ready_idx", 32'(o_first), 32'd4);
        check("w3_busy_cycles", 32'(o_busy), 32'd5);
        do_req(1'b1, 2'b10, 1'b0, 9'd8, 32'h12345678);
        observe(1'b0);
        check("w3_store_ready", 32'(o_rcnt), 32'd1);
        do_req(1'b0, 2'b10, 1'b0, 9'd8, 32'h0);
        observe(1'b0);
        check("w3_store_readback", o_d0, 32'h12345678);
        sel3 = 1'b0;

        check("ready_misaligned_overlap", 32'(both_cnt), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/data_mem_ctrl.md
Name: data_mem_ctrl

Overview:
Parametrised, byte-addressed, big-endian SPARC data memory with a request/ready handshake, configurable access latency and byte/halfword/word/doubleword modes. It is the next generation of the 512x8 instruction ROM: it adds writes, size modes, sign extension, alignment checking and multi-cycle doubleword transfers. It sits on the MEM stage of the pipeline and is preloaded through hierarchical access to its byte array `Mem`.

Parameters:
ADDR_WIDTH, 9, byte-address width; the array holds 2**ADDR_WIDTH bytes.
WAIT_CYCLES, 0, extra wait states inserted before each access (0..15).

Ports:
clk  input  1  system clock; all state changes on the rising edge.
clr  input  1  asynchronous, active-high reset.
req  input  1  request strobe; sampled only in IDLE.
rw  input  1  0 = load, 1 = store.
size  input  2  00 byte, 01 halfword, 10 word, 11 doubleword.
signed_ld  input  1  sign-extend byte and halfword loads.
addr  input  ADDR_WIDTH  byte address; latched at request acceptance.
data_in  input  32  store data; byte in [7:0], halfword in [15:0]; sampled at each access edge.
data_out  output  32  load data; registered.
busy  output  1  high whenever state != IDLE.
ready  output  1  one-cycle pulse per transferred word.
dw_second  output  1  qualifies ready: the second word of a doubleword.
misaligned  output  1  one-cycle pulse on a rejected request.

Behaviour:
- Reset (clr=1, any time, asynchronous):
  - state = IDLE; wait counter = 0.
  - data_out, busy, ready, dw_second and misaligned all = 0.
  - Mem contents are not cleared.
  - Reset mid-operation aborts it; bytes already stored remain stored.
- States: IDLE, WAIT, XFER2, DONE.
- IDLE, req=1 at edge k:
  - Alignment check. Misaligned means: halfword with addr[0]=1; word with addr[1:0]!=0; doubleword with addr[2:0]!=0.
  - If misaligned: misaligned=1 for the cycle after edge k, state stays IDLE, no memory access, ready stays 0.
  - Otherwise: latch addr/size/rw/signed_ld, load counter = WAIT_CYCLES, go to WAIT.
- WAIT, at each edge:
  - If counter != 0, decrement it.
  - If counter == 0, perform the access (below) and set ready=1.
  - Next state is XFER2 if size=11, else DONE.
  - Net effect: the first ready is high in the cycle after edge k+1+WAIT_CYCLES.
- XFER2 (doubleword only), next edge:
  - Access the second word at latched addr+4.
  - ready=1, dw_second=1, go to DONE.
- DONE, next edge: ready=0, dw_second=0, go to IDLE.
- Busy duration: WAIT_CYCLES+2 cycles for a single access, WAIT_CYCLES+3 for a doubleword.
- req while busy is ignored; no queueing.
- Access (big-endian, Mem[a] is the most significant byte):
  - Load byte: {24 ext, Mem[a]}.
  - Load halfword: {16 ext, Mem[a], Mem[a+1]}.
  - Load word: {Mem[a], Mem[a+1], Mem[a+2], Mem[a+3]}.
  - ext is the MSB of the loaded data when signed_ld=1, else 0. signed_ld is ignored for word and doubleword.
  - Store: writes the same byte lanes from data_in at the access edge.
  - data_out is unchanged by stores and holds its value until the next load access.
- Address arithmetic is modulo 2**ADDR_WIDTH. Aligned accesses never cross the top of the array, so no wrap occurs.
- ready and misaligned are never high in the same cycle.

Test Plan:
1. Preload Mem[0..7] = 81,02,03,04,05,06,07,08 (hex), WAIT_CYCLES=2, word load at addr 0 → ready in the single cycle after edge k+3; data_out=32'h81020304; busy high for 4 cycles.
2. Byte load at addr 0 with signed_ld=1 → 32'hFFFFFF81. Same with signed_ld=0 → 32'h00000081. Halfword signed load at addr 0 → 32'hFFFF8102.
3. Doubleword load at addr 0 → two consecutive ready cycles:
   - 32'h81020304 with dw_second=0;
   - then 32'h05060708 with dw_second=1.
   - A req pulsed mid-transfer is ignored.
4. Byte store data_in=32'h000000AA at addr 5, then word load at addr 4 → 32'h05AA0708. Halfword store 16'hBEEF at addr 2, then word load at addr 0 → 32'h8102BEEF.
5. Word load at addr 2 → misaligned=1 for exactly one cycle; busy=0, ready=0, Mem unchanged. Doubleword at addr 4 → misaligned. Doubleword at addr 504 → words from 504 and 508.
6. Assert clr during WAIT of a word store (WAIT_CYCLES=3) → busy and ready drop immediately, target bytes unchanged. A fresh request after release completes normally.
